// File: rtl/output_port_arbiter.sv
// Switch allocator for one router output port: round-robin pick,
// wormhole lock until tail, and downstream credit tracking.
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   req         per-input request for this output
//   tail        per-input head flit is the packet's last flit
//   credit_in   downstream freed one buffer slot (1-cycle pulse)
//   sel         one-hot mux select (registered owner), 0 when idle
//   grant_fire  one-hot, input whose flit crosses this cycle
//   out_valid   a flit is on the mux output this cycle
//   busy        locked to a packet
//   credits     current downstream credit count
//   credit_err  sticky credit overflow flag
module output_port_arbiter #(
  parameter int NPORT   = 5,
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] tail,
  input  logic             credit_in,
  output logic [NPORT-1:0] sel,
  output logic [NPORT-1:0] grant_fire,
  output logic             out_valid,
  output logic             busy,
  output logic [CW-1:0]    credits,
  output logic             credit_err
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [NPORT-1:0] owner_q;
  logic [NPORT-1:0] owner_d;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    ptr_d;
  logic [CW-1:0]    cred_q;
  logic [CW-1:0]    cred_d;
  logic             err_q;
  logic             err_d;

  logic             fire;
  logic             own_tail;
  logic [PW:0]      rot_amt;
  logic [2*NPORT-1:0] req_dbl;
  logic [2*NPORT-1:0] req_rot;
  logic [NPORT-1:0] rot_req;
  logic [NPORT-1:0] rot_oh;
  logic [2*NPORT-1:0] oh_dbl;
  logic [NPORT-1:0] win_oh;
  logic [PW-1:0]    own_idx;

  // Rotate req so bit 0 is the input just after ptr, take
  // the lowest set bit, then rotate the one-hot back.
  always_comb begin
    rot_amt = {1'b0, ptr_q} + 1'b1;
    req_dbl = {req, req};
    req_rot = req_dbl >> rot_amt;
    rot_req = req_rot[NPORT-1:0];
    rot_oh  = rot_req & (~rot_req + 1'b1);
    oh_dbl  = {rot_oh, rot_oh} << rot_amt;
    win_oh  = oh_dbl[2*NPORT-1:NPORT];
  end

  always_comb begin
    own_idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (owner_q[i]) own_idx = PW'(i);
    end
  end

  assign own_tail = |(tail & owner_q);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= PW'(NPORT - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = win_oh;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (fire && own_tail) begin
          owner_d = '0;
          ptr_d   = own_idx;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase
  end

  // Outputs; fire is suppressed while reset is asserted so an
  // input is never popped in the cycle the lock is dropped.
  always_comb begin
    fire = 1'b0;
    busy = 1'b0;
    sel  = owner_q;
    if (state_q == LOCKED) begin
      busy = 1'b1;
      fire = rst_n && (|(req & owner_q)) && (cred_q != '0);
    end
    grant_fire = owner_q & {NPORT{fire}};
    out_valid  = |grant_fire;
  end

  // Credit counter and sticky overflow flag
  always_comb begin
    cred_d = cred_q;
    err_d  = err_q;
    case ({credit_in, fire})
      2'b10: begin
        if (cred_q == CW'(CREDITS)) err_d = 1'b1;
        else cred_d = cred_q + 1'b1;
      end
      2'b01: cred_d = cred_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cred_q <= CW'(CREDITS);
      err_q  <= 1'b0;
    end else begin
      cred_q <= cred_d;
      err_q  <= err_d;
    end
  end

  assign credits    = cred_q;
  assign credit_err = err_q;

  a_sel_onehot : assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(sel));
  a_sel_idle : assert property (
    @(posedge clk) disable iff (!rst_n)
    (sel == '0) == (state_q == IDLE));
  a_fire_sub : assert property (
    @(posedge clk) disable iff (!rst_n)
    (grant_fire & ~sel) == '0);

endmodule
